// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, FSM states and width helper for BCD datapaths
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd2bin_state_e;

    // ceil(log2(10^n)): bits needed to hold the largest n-digit decimal value.
    // Exact for n <= 19 (10^n fits in 64 bits).
    function automatic int bin_width_for_digits(input int n);
        logic [63:0] p;
        int          w;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        w = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) < p) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// rtl/bcd_mul10_add.sv - combinational acc*10 + digit, truncated to BIN_WIDTH
//
// Ports:
//   acc_in  [BIN_WIDTH-1:0]  running accumulator
//   digit   [3:0]            decimal digit to append (values >9 folded as-is)
//   acc_out [BIN_WIDTH-1:0]  (acc_in*10 + digit) mod 2^BIN_WIDTH
module bcd_mul10_add
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 10
) (
    input  logic [BIN_WIDTH-1:0] acc_in,
    input  bcd_digit_t           digit,
    output logic [BIN_WIDTH-1:0] acc_out
);

    logic [BIN_WIDTH-1:0] digit_ext;

    // x*10 = x*8 + x*2; everything stays at BIN_WIDTH so overflow wraps.
    always_comb begin
        digit_ext = BIN_WIDTH'(digit);
        acc_out   = (acc_in << 3) + (acc_in << 1) + digit_ext;
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter, one digit per clock
//
// Folds a packed NUM_DIGITS BCD word MSD-first with Horner's rule.
// Optional digit-range checking is built when BCD2BIN_CHECK_EN is defined;
// otherwise err is tied low.
//
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   load    start (or restart) a conversion, samples bcd_in
//   bcd_in  [NUM_DIGITS-1:0][3:0] packed BCD, index NUM_DIGITS-1 is the MSD
//   binary  [BIN_WIDTH-1:0] last completed result, held until next completion
//   busy    conversion in progress
//   done    one-cycle pulse when binary updates
//   err     a digit >9 was present in the word that produced binary
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_WIDTH  = bin_width_for_digits(NUM_DIGITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [NUM_DIGITS-1:0][3:0] bcd_in,
    output logic [BIN_WIDTH-1:0]       binary,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int SREG_W = NUM_DIGITS * 4;
    localparam int CNT_W  = $clog2(NUM_DIGITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("bcd_to_binary_seq: NUM_DIGITS must be >= 1");
    end
    if (BIN_WIDTH < 1) begin : g_bad_bin_width
        $error("bcd_to_binary_seq: BIN_WIDTH must be >= 1");
    end

    bcd2bin_state_e       state_q, state_d;
    logic [BIN_WIDTH-1:0] acc_q, acc_d;
    logic [SREG_W-1:0]    sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] binary_q, binary_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BIN_WIDTH-1:0] acc_next;
    logic                 fold_last;

    bcd_mul10_add #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_mul10_add (
        .acc_in  (acc_q),
        .digit   (sreg_q[SREG_W-1 -: 4]),
        .acc_out (acc_next)
    );

    // Final fold of a conversion that is not being pre-empted by a reload.
    assign fold_last = !load && (state_q == RUN) && (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;

        if (load) begin
            // Reload wins from any state; an in-flight result is discarded.
            state_d = RUN;
            acc_d   = '0;
            sreg_d  = bcd_in;
            cnt_d   = CNT_LOAD;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    acc_d  = acc_next;
                    sreg_d = sreg_q << 4;
                    cnt_d  = cnt_q - 1'b1;
                    if (fold_last) begin
                        binary_d = acc_next;
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Status outputs are registered decodes of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sreg_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign binary = binary_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef BCD2BIN_CHECK_EN
    // Invalid-digit flag is captured with the word and published with its result.
    logic bad_word;
    logic chk_q, chk_d;
    logic err_q, err_d;

    always_comb begin
        bad_word = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[i] > 4'd9) begin
                bad_word = 1'b1;
            end
        end
        chk_d = load ? bad_word : chk_q;
        err_d = fold_last ? chk_q : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

`ifdef BCD2BIN_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [2:0][3:0]  bcd_in;
    logic [9:0]       binary;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_binary_seq #(
        .NUM_DIGITS (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bcd_in (bcd_in),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          exp_bin;
        bit          invalid;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Load one word and check the exact cycle-by-cycle response.
    task automatic run_vec(input string name, input logic [11:0] bcd,
                           input int exp_bin, input bit exp_err);
        @(negedge clk);
        bcd_in = bcd;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk({name, " busy@k"}, int'(busy), 1);
        chk({name, " done@k"}, int'(done), 0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk({name, " busy@run"}, int'(busy), 1);
            chk({name, " done@run"}, int'(done), 0);
        end
        @(posedge clk);
        #1;
        chk({name, " done@k+3"}, int'(done), 1);
        chk({name, " busy@k+3"}, int'(busy), 0);
        chk({name, " binary"}, int'(binary), exp_bin);
        chk({name, " err"}, int'(err), int'(exp_err));
        @(posedge clk);
        #1;
        chk({name, " done@k+4"}, int'(done), 0);
    endtask

    int  done_cnt;
    int  done_cyc;
    bit  saw_123;
    int  bin_at_done;

    initial begin
        vecs[0] = '{12'h259, 259,  1'b0};
        vecs[1] = '{12'h999, 999,  1'b0};
        vecs[2] = '{12'h000, 0,    1'b0};
        vecs[3] = '{12'h2A5, 305,  1'b1};
        vecs[4] = '{12'hFFF, 641,  1'b1};   // 1665 mod 1024
        vecs[5] = '{12'h909, 909,  1'b0};
        vecs[6] = '{12'hF09, 485,  1'b1};   // 1509 mod 1024
        vecs[7] = '{12'hA00, 1000, 1'b1};

        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset binary", int'(binary), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_vec($sformatf("vec%0d", v), vecs[v].bcd, vecs[v].exp_bin,
                    vecs[v].invalid && CHECK_ON);
        end

        // Reload one clock after the first load: only the second word completes.
        @(negedge clk);
        bcd_in = 12'h123;
        load   = 1'b1;
        @(negedge clk);
        bcd_in = 12'h456;
        @(posedge clk);
        #1;
        load        = 1'b0;
        done_cnt    = 0;
        done_cyc    = 0;
        saw_123     = 1'b0;
        bin_at_done = -1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (binary == 10'd123) saw_123 = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc    = c;
                bin_at_done = int'(binary);
            end
        end
        chk("reload done count", done_cnt, 1);
        chk("reload done cycle", done_cyc, 3);
        chk("reload binary", bin_at_done, 456);
        chk("reload never 123", int'(saw_123), 0);

        // Reset on the second RUN clock drops the conversion.
        @(negedge clk);
        bcd_in = 12'h777;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst binary", int'(binary), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("rst no done", done_cnt, 0);
        run_vec("after rst", 12'h001, 1, 1'b0);

        // Back-to-back: reload during the DONE cycle.
        @(negedge clk);
        bcd_in = 12'h654;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b first done", int'(done), 1);
        chk("b2b first binary", int'(binary), 654);
        bcd_in = 12'h321;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("b2b done cleared", int'(done), 0);
        chk("b2b busy", int'(busy), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b done early", int'(done), 0);
        @(posedge clk);
        #1;
        chk("b2b second done", int'(done), 1);
        chk("b2b second binary", int'(binary), 321);

        // Held load restarts every cycle and never completes.
        @(negedge clk);
        load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bcd_in = {4'(i + 1), 4'(i), 4'(9 - i)};
            @(posedge clk);
            #1;
            chk("hold no done", int'(done), 0);
            chk("hold busy", int'(busy), 1);
        end
        chk("hold binary kept", int'(binary), 321);
        load     = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6 && done_cnt == 0; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("hold release done", done_cnt, 1);
        chk("hold release binary", int'(binary), 654);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
